fetch_pc_unit: RTL and testbench

Fetch-stage program-counter unit that sits directly upstream of the branch predictor and consumes its outputs. Each cycle it selects the next fetch PC from four sources: sequential (PC+4), BTB predicted target, mispredict recovery, or a held PC under stall. It also keeps the F→D prediction record that lets decode resolve mispredictions, raises the decode flush, and counts mispredictions.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_pc_unit_if.sv | 40 ++++
 rtl/sat_counter.sv | 21 ++
 rtl/fetch_pc_unit.sv | 95 +++++++++
 tb/tb_fetch_pc_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC unit.
// Contents: PC width, default reset address, FSM state encoding and the
// F->D prediction record layout carried into decode.
package fetch_pkg;

  localparam int          PC_W             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // RECOVER marks the single cycle after a redirect in which the
  // predictor's outputs are stale and must not be trusted.
  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic            pred_taken;
    logic            valid;
  } dec_rec_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle of every non-clock signal of the fetch PC unit.
// master: the surrounding pipeline (hazard unit, predictor, decode); it drives
//         stalls, predictions and branch resolution and observes the PC outputs.
// slave : the fetch PC unit itself.
interface fetch_pc_unit_if #(
  parameter int CNT_W = 16
) ();

  logic             stall_F;
  logic             stall_D;
  logic             pred_sel_F;
  logic [31:0]      pred_target_F;
  logic             branch_D;
  logic             mispred_taken_D;
  logic             mispred_not_taken_D;
  logic [31:0]      pc_branch_D;
  logic [31:0]      pc_F;
  logic [31:0]      pc_plus4_F;
  logic [31:0]      pc_D;
  logic [31:0]      pc_plus4_D;
  logic             pred_taken_D;
  logic             valid_D;
  logic             flush_D;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output stall_F, stall_D, pred_sel_F, pred_target_F, branch_D,
           mispred_taken_D, mispred_not_taken_D, pc_branch_D,
    input  pc_F, pc_plus4_F, pc_D, pc_plus4_D, pred_taken_D, valid_D,
           flush_D, mispred_count
  );

  modport slave (
    input  stall_F, stall_D, pred_sel_F, pred_target_F, branch_D,
           mispred_taken_D, mispred_not_taken_D, pc_branch_D,
    output pc_F, pc_plus4_F, pc_D, pc_plus4_D, pred_taken_D, valid_D,
           flush_D, mispred_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
// Holds at all-ones once reached; reusable for hit/lookup statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program-counter unit.
// Ports: clk, rst_n (async active-low), bus (fetch_pc_unit_if.slave).
// Selects the next fetch PC (recovery > stall hold > predicted target > PC+4),
// keeps the F->D prediction record, raises flush_D on a redirect and counts
// redirects in a saturating counter.
import fetch_pkg::*;

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_unit_if.slave bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] recover_pc;
  dec_rec_t        dec_q;
  fetch_state_e    state;
  logic            redirect;
  logic            pred_ok;

  // The predictor drives its mispredict flags from state when decode holds
  // no branch, so branch_D qualifies them; a stalled decode cannot redirect.
  assign redirect   = bus.branch_D & ~bus.stall_D &
                      (bus.mispred_taken_D | bus.mispred_not_taken_D);
  assign recover_pc = bus.mispred_taken_D ? bus.pc_branch_D : dec_q.pc_plus4;
  // The predictor is updated on the redirect edge, so its output in the
  // following cycle describes the old state and is ignored.
  assign pred_ok    = bus.pred_sel_F & (state == RUN);
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = recover_pc;
    end else if (bus.stall_F) begin
      pc_next = pc_q;
    end else if (pred_ok) begin
      pc_next = bus.pred_target_F;
    end
  end

  // Fetch stage: PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // F->D boundary: a stalled fetch loads an invalid record (bubble)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
    end else if (redirect) begin
      dec_q <= '0;
    end else if (!bus.stall_D) begin
      dec_q <= '{pc: pc_q, pc_plus4: pc_plus4, pred_taken: pred_ok,
                 valid: ~bus.stall_F};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= redirect ? RECOVER : RUN;
        RECOVER: state <= redirect ? RECOVER : RUN;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (bus.mispred_count)
  );

  assign bus.pc_F         = pc_q;
  assign bus.pc_plus4_F   = pc_plus4;
  assign bus.pc_D         = dec_q.pc;
  assign bus.pc_plus4_D   = dec_q.pc_plus4;
  assign bus.pred_taken_D = dec_q.pred_taken;
  assign bus.valid_D      = dec_q.valid;
  assign bus.flush_D      = redirect;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit (RESET_PC=32'h100, CNT_W=2).
// A table of per-cycle stimulus records with hand-derived expected results
// is driven on the falling edge; expectations go into a scoreboard queue and
// are popped and compared just after the next rising edge.
module tb_fetch_pc_unit;

  logic clk;
  logic rst_n;

  fetch_pc_unit_if #(.CNT_W(2)) bus ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0100), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sf, sd, ps;
    logic [31:0] pt;
    logic        br, mt, mnt;
    logic [31:0] pb;
    logic        flush;
    logic [31:0] pc, pcd, pc4d;
    logic        ptd, vd;
    logic [1:0]  cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc, pcd, pc4d;
    logic        ptd, vd;
    logic [1:0]  cnt;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[18];
  exp_t sb[$];

  function automatic vec_t mk(logic sf, logic sd, logic ps, logic [31:0] pt,
                              logic br, logic mt, logic mnt, logic [31:0] pb,
                              logic flush, logic [31:0] pc, logic [31:0] pcd,
                              logic [31:0] pc4d, logic ptd, logic vd,
                              logic [1:0] cnt);
    vec_t v;
    v.sf = sf; v.sd = sd; v.ps = ps; v.pt = pt;
    v.br = br; v.mt = mt; v.mnt = mnt; v.pb = pb;
    v.flush = flush; v.pc = pc; v.pcd = pcd; v.pc4d = pc4d;
    v.ptd = ptd; v.vd = vd; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.stall_F             = v.sf;
    bus.stall_D             = v.sd;
    bus.pred_sel_F          = v.ps;
    bus.pred_target_F       = v.pt;
    bus.branch_D            = v.br;
    bus.mispred_taken_D     = v.mt;
    bus.mispred_not_taken_D = v.mnt;
    bus.pc_branch_D         = v.pb;
  endtask

  task automatic idle();
    drive(mk(0,0,0,32'h0,0,0,0,32'h0,0,0,0,0,0,0,2'd0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc_F"},       bus.pc_F,         32'h100);
    chk({tag, ".pc_plus4_F"}, bus.pc_plus4_F,   32'h104);
    chk({tag, ".pc_D"},       bus.pc_D,         32'h0);
    chk({tag, ".pc_plus4_D"}, bus.pc_plus4_D,   32'h0);
    chk({tag, ".pred_tk_D"},  {31'd0, bus.pred_taken_D}, 32'd0);
    chk({tag, ".valid_D"},    {31'd0, bus.valid_D},      32'd0);
    chk({tag, ".count"},      {30'd0, bus.mispred_count}, 32'd0);
    chk({tag, ".flush_D"},    {31'd0, bus.flush_D},      32'd0);
  endtask

  initial begin
    //        sf sd ps pt            br mt mnt pb          fl pc            pc_D          pc4_D         ptd vd cnt
    tbl[0]  = mk(0,0,0,32'h0,        0,0,0,32'h0,        0,32'h104,      32'h100,      32'h104,      0,1,2'd0);
    tbl[1]  = mk(0,0,1,32'h200,      0,0,0,32'h0,        0,32'h200,      32'h104,      32'h108,      1,1,2'd0);
    tbl[2]  = mk(0,0,1,32'h300,      1,0,1,32'h0,        1,32'h108,      32'h0,        32'h0,        0,0,2'd1);
    tbl[3]  = mk(0,0,1,32'h300,      0,0,0,32'h0,        0,32'h10C,      32'h108,      32'h10C,      0,1,2'd1);
    tbl[4]  = mk(0,0,0,32'h0,        0,0,0,32'h0,        0,32'h110,      32'h10C,      32'h110,      0,1,2'd1);
    tbl[5]  = mk(1,0,0,32'h0,        1,1,0,32'h400,      1,32'h400,      32'h0,        32'h0,        0,0,2'd2);
    tbl[6]  = mk(0,0,0,32'h0,        1,1,0,32'h500,      1,32'h500,      32'h0,        32'h0,        0,0,2'd3);
    tbl[7]  = mk(0,0,1,32'h600,      0,0,0,32'h0,        0,32'h504,      32'h500,      32'h504,      0,1,2'd3);
    tbl[8]  = mk(0,0,0,32'h0,        0,1,1,32'h700,      0,32'h508,      32'h504,      32'h508,      0,1,2'd3);
    tbl[9]  = mk(0,1,0,32'h0,        1,1,0,32'h700,      0,32'h50C,      32'h504,      32'h508,      0,1,2'd3);
    tbl[10] = mk(1,0,0,32'h0,        0,0,0,32'h0,        0,32'h50C,      32'h50C,      32'h510,      0,0,2'd3);
    tbl[11] = mk(1,1,0,32'h0,        0,0,0,32'h0,        0,32'h50C,      32'h50C,      32'h510,      0,0,2'd3);
    tbl[12] = mk(0,1,1,32'h800,      0,0,0,32'h0,        0,32'h800,      32'h50C,      32'h510,      0,0,2'd3);
    tbl[13] = mk(0,0,0,32'h0,        1,1,1,32'h900,      1,32'h900,      32'h0,        32'h0,        0,0,2'd3);
    tbl[14] = mk(0,0,0,32'h0,        1,0,1,32'h0,        1,32'h0,        32'h0,        32'h0,        0,0,2'd3);
    tbl[15] = mk(0,0,0,32'h0,        0,0,0,32'h0,        0,32'h4,        32'h0,        32'h4,        0,1,2'd3);
    tbl[16] = mk(0,0,1,32'hFFFF_FFFC,0,0,0,32'h0,        0,32'hFFFF_FFFC,32'h4,        32'h8,        1,1,2'd3);
    tbl[17] = mk(0,0,0,32'h0,        0,0,0,32'h0,        0,32'h0,        32'hFFFF_FFFC,32'h0,        0,1,2'd3);

    rst_n = 1'b0;
    idle();
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      exp_t e;
      drive(tbl[i]);
      e.idx = i; e.pc = tbl[i].pc; e.pcd = tbl[i].pcd; e.pc4d = tbl[i].pc4d;
      e.ptd = tbl[i].ptd; e.vd = tbl[i].vd; e.cnt = tbl[i].cnt;
      sb.push_back(e);
      #1;
      chk($sformatf("v%0d.flush_D", i), {31'd0, bus.flush_D}, {31'd0, tbl[i].flush});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard empty", i);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk($sformatf("v%0d.pc_F", x.idx),       bus.pc_F,       x.pc);
        chk($sformatf("v%0d.pc_plus4_F", x.idx), bus.pc_plus4_F, x.pc + 32'd4);
        chk($sformatf("v%0d.pc_D", x.idx),       bus.pc_D,       x.pcd);
        chk($sformatf("v%0d.pc_plus4_D", x.idx), bus.pc_plus4_D, x.pc4d);
        chk($sformatf("v%0d.pred_tk_D", x.idx),  {31'd0, bus.pred_taken_D}, {31'd0, x.ptd});
        chk($sformatf("v%0d.valid_D", x.idx),    {31'd0, bus.valid_D},      {31'd0, x.vd});
        chk($sformatf("v%0d.count", x.idx),      {30'd0, bus.mispred_count}, {30'd0, x.cnt});
      end
      @(negedge clk);
    end

    // Asynchronous reset between a redirect and the following edge.
    drive(mk(1,0,0,32'h0,1,1,0,32'hA00,0,0,0,0,0,0,2'd0));
    #1;
    chk("ar.flush_pre", {31'd0, bus.flush_D}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.pc_F_async", bus.pc_F, 32'h100);
    idle();
    #1;
    chk_reset_state("ar");
    @(posedge clk);
    #1;
    chk("ar.pc_F_held", bus.pc_F, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar.first_fetch", bus.pc_F, 32'h100);
    @(posedge clk);
    #1;
    chk("ar.pc_F_next", bus.pc_F,    32'h104);
    chk("ar.pc_D_next", bus.pc_D,    32'h100);
    chk("ar.valid_next", {31'd0, bus.valid_D}, 32'd1);
    chk("ar.count_next", {30'd0, bus.mispred_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
